mem_arbiter: RTL and testbench

- Arbitrates the single-port, byte-wide unified RAM between the instruction-fetch stage and the MEM stage.
- Sequences multi-byte word/half/byte transfers as byte-serial RAM cycles.
- Returns a one-cycle done pulse with the assembled data, which feeds the IF/ID register's get_inst.
- Raises a stall request toward the pipeline controller while a data access is outstanding.

---
 rtl/mem_arbiter_if.sv | 49 ++++
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of signals between the unified-RAM arbiter, its two pipeline requesters and the byte RAM.
// The slave modport is the arbiter's view; the master modport is everything around it.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32
);
    // instruction fetch port
    logic                  if_req_i;
    logic [ADDR_WIDTH-1:0] if_addr_i;
    logic                  if_flush_i;
    logic                  if_done_o;
    logic [31:0]           if_inst_o;

    // data (MEM stage) port
    logic                  mem_req_i;
    logic                  mem_we_i;
    logic [1:0]            mem_size_i;
    logic [ADDR_WIDTH-1:0] mem_addr_i;
    logic [31:0]           mem_wdata_i;
    logic                  mem_done_o;
    logic [31:0]           mem_rdata_o;

    // byte-wide RAM
    logic [7:0]            ram_din_i;
    logic [7:0]            ram_dout_o;
    logic [ADDR_WIDTH-1:0] ram_a_o;
    logic                  ram_wr_o;

    logic                  stallreq_o;

    modport slave (
        input  if_req_i, if_addr_i, if_flush_i,
        output if_done_o, if_inst_o,
        input  mem_req_i, mem_we_i, mem_size_i, mem_addr_i, mem_wdata_i,
        output mem_done_o, mem_rdata_o,
        input  ram_din_i,
        output ram_dout_o, ram_a_o, ram_wr_o,
        output stallreq_o
    );

    modport master (
        output if_req_i, if_addr_i, if_flush_i,
        input  if_done_o, if_inst_o,
        output mem_req_i, mem_we_i, mem_size_i, mem_addr_i, mem_wdata_i,
        input  mem_done_o, mem_rdata_o,
        output ram_din_i,
        input  ram_dout_o, ram_a_o, ram_wr_o,
        input  stallreq_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM between instruction fetch and the MEM stage, splitting each
// word/half/byte access into byte-serial RAM cycles; MEM always wins arbitration.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        IF_RD,
        MEM_RD,
        MEM_WR
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] ram_a_q;
    logic [2:0]            cnt_q;
    logic [2:0]            len_q;
    logic [31:0]           wdata_q;
    logic [31:0]           acc_q;
    logic [31:0]           if_inst_q;
    logic [31:0]           mem_rdata_q;
    logic [7:0]            ram_dout_q;
    logic                  ram_wr_q;
    logic                  if_done_q;
    logic                  mem_done_q;

    logic [2:0]            cnt_inc;
    logic                  last_beat;
    logic [ADDR_WIDTH-1:0] ram_a_d;
    logic [31:0]           acc_d;
    logic [7:0]            wlane [4];
    logic [7:0]            wbyte_d;
    logic [2:0]            req_len;
    logic                  any_done;

    // beat k = cnt_q + 1 is the one completed at the current edge
    assign cnt_inc   = cnt_q + 3'd1;
    assign last_beat = (cnt_inc == len_q);
    assign ram_a_d   = base_q + ADDR_WIDTH'(cnt_inc);
    assign any_done  = if_done_q | mem_done_q;

    always_comb begin
        req_len = 3'd4;
        case (bus.mem_size_i)
            2'b00:   req_len = 3'd1;
            2'b01:   req_len = 3'd2;
            default: req_len = 3'd4;
        endcase
    end

    // byte lane of the incoming RAM data merges into the accumulator at lane cnt_q
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign acc_d[gi*8 +: 8] = (cnt_q[1:0] == 2'(gi)) ? bus.ram_din_i : acc_q[gi*8 +: 8];
        assign wlane[gi]        = wdata_q[gi*8 +: 8];
    end

    assign wbyte_d = wlane[cnt_inc[1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            base_q      <= '0;
            ram_a_q     <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            wdata_q     <= '0;
            acc_q       <= '0;
            if_inst_q   <= '0;
            mem_rdata_q <= '0;
            ram_dout_q  <= '0;
            ram_wr_q    <= 1'b0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // a done pulse this cycle forces one turnaround cycle with no grant
                    if (!any_done) begin
                        if (bus.mem_req_i) begin
                            base_q  <= bus.mem_addr_i;
                            ram_a_q <= bus.mem_addr_i;
                            len_q   <= req_len;
                            wdata_q <= bus.mem_wdata_i;
                            cnt_q   <= '0;
                            acc_q   <= '0;
                            if (bus.mem_we_i) begin
                                state_q    <= MEM_WR;
                                ram_wr_q   <= 1'b1;
                                ram_dout_q <= bus.mem_wdata_i[7:0];
                            end else begin
                                state_q <= MEM_RD;
                            end
                        end else if (bus.if_req_i && !bus.if_flush_i) begin
                            base_q  <= bus.if_addr_i;
                            ram_a_q <= bus.if_addr_i;
                            len_q   <= 3'd4;
                            cnt_q   <= '0;
                            acc_q   <= '0;
                            state_q <= IF_RD;
                        end
                    end
                end
                IF_RD, MEM_RD: begin
                    if (state_q == IF_RD && bus.if_flush_i) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        acc_q <= acc_d;
                        if (last_beat) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            if (state_q == IF_RD) begin
                                if_done_q <= 1'b1;
                                if_inst_q <= acc_d;
                            end else begin
                                mem_done_q  <= 1'b1;
                                mem_rdata_q <= acc_d;
                            end
                        end else begin
                            ram_a_q <= ram_a_d;
                            cnt_q   <= cnt_inc;
                        end
                    end
                end
                MEM_WR: begin
                    if (last_beat) begin
                        ram_wr_q   <= 1'b0;
                        mem_done_q <= 1'b1;
                        state_q    <= IDLE;
                        cnt_q      <= '0;
                    end else begin
                        ram_a_q    <= ram_a_d;
                        ram_dout_q <= wbyte_d;
                        cnt_q      <= cnt_inc;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.if_done_o   = if_done_q;
    assign bus.if_inst_o   = if_inst_q;
    assign bus.mem_done_o  = mem_done_q;
    assign bus.mem_rdata_o = mem_rdata_q;
    assign bus.ram_a_o     = ram_a_q;
    assign bus.ram_dout_o  = ram_dout_q;
    assign bus.ram_wr_o    = ram_wr_q;
    assign bus.stallreq_o  = bus.mem_req_i & ~mem_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: byte-addressed reference RAM, expected results queued at
// issue time and popped by an independent monitor on every done pulse.
module tb_mem_arbiter;

    logic clk;
    logic rst;

    mem_arbiter_if #(.ADDR_WIDTH(32)) bus ();

    mem_arbiter #(.ADDR_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_if[$];
    logic [31:0] exp_mem[$];
    logic [31:0] last_inst;
    logic [31:0] last_rdata;

    // RAM attached to the DUT, and the reference RAM kept by the model
    logic [7:0] dut_ram   [16384];
    bit         dut_vld   [16384];
    logic [7:0] model_ram [16384];
    bit         model_vld [16384];

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        case (a)
            32'h100: return 8'h13;
            32'h101: return 8'h05;
            32'h102: return 8'h10;
            32'h103: return 8'h00;
            32'h010: return 8'h7F;
            default: return a[7:0] ^ {a[3:0], a[7:4]} ^ a[15:8] ^ 8'h3C;
        endcase
    endfunction

    function automatic logic [7:0] dut_rd(input logic [31:0] a);
        return dut_vld[a[13:0]] ? dut_ram[a[13:0]] : init_byte(a);
    endfunction

    function automatic logic [7:0] model_rd(input logic [31:0] a);
        return model_vld[a[13:0]] ? model_ram[a[13:0]] : init_byte(a);
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input int n);
        logic [31:0] w = '0;
        for (int k = 0; k < n; k++) w[8*k +: 8] = model_rd(addr + 32'(k));
        return w;
    endfunction

    task automatic model_store(input logic [31:0] addr, input int n, input logic [31:0] wd);
        for (int k = 0; k < n; k++) begin
            logic [31:0] a = addr + 32'(k);
            model_ram[a[13:0]] = wd[8*k +: 8];
            model_vld[a[13:0]] = 1'b1;
        end
    endtask

    // registered RAM: write at the edge, read data settled at the falling edge
    always @(posedge clk) begin
        if (bus.ram_wr_o) begin
            dut_ram[bus.ram_a_o[13:0]] <= bus.ram_dout_o;
            dut_vld[bus.ram_a_o[13:0]] <= 1'b1;
        end
    end

    always @(negedge clk) bus.ram_din_i <= dut_rd(bus.ram_a_o);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: pops the scoreboard on every done pulse, checks stall request every cycle
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (bus.if_done_o) begin
                if (exp_if.size() == 0) check("if_done_unexpected", {31'b0, bus.if_done_o}, 32'h0);
                else check("if_inst", bus.if_inst_o, exp_if.pop_front());
            end
            if (bus.mem_done_o) begin
                if (exp_mem.size() == 0) check("mem_done_unexpected", {31'b0, bus.mem_done_o}, 32'h0);
                else check("mem_rdata", bus.mem_rdata_o, exp_mem.pop_front());
            end
            if (!rst) check("stallreq", {31'b0, bus.stallreq_o}, {31'b0, bus.mem_req_i & ~bus.mem_done_o});
        end
    end

    task automatic mem_op(input bit we, input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wd);
        int n = nbytes(sz);
        int cyc = 0;
        bus.mem_req_i   = 1'b1;
        bus.mem_we_i    = we;
        bus.mem_size_i  = sz;
        bus.mem_addr_i  = addr;
        bus.mem_wdata_i = wd;
        if (we) model_store(addr, n, wd);
        else last_rdata = model_load(addr, n);
        exp_mem.push_back(last_rdata);
        do begin
            @(negedge clk);
            cyc++;
            if (cyc <= n) begin
                check("mem_ram_a", bus.ram_a_o, addr + 32'(cyc - 1));
                check("mem_ram_wr", {31'b0, bus.ram_wr_o}, {31'b0, we});
                if (we) check("mem_ram_dout", {24'b0, bus.ram_dout_o}, {24'b0, wd[8*(cyc-1) +: 8]});
            end
        end while (!bus.mem_done_o && cyc < 40);
        check("mem_wr_off_at_done", {31'b0, bus.ram_wr_o}, 32'h0);
        bus.mem_req_i = 1'b0;
        check("mem_latency", 32'(cyc), 32'(n + 1));
        @(negedge clk);
    endtask

    // flush_at = 0: normal fetch; otherwise flush is raised at that falling edge after the request
    task automatic if_op(input logic [31:0] addr, input int flush_at);
        int cyc = 0;
        int seen = 0;
        bus.if_addr_i = addr;
        bus.if_req_i  = 1'b1;
        if (flush_at == 0) begin
            last_inst = model_load(addr, 4);
            exp_if.push_back(last_inst);
            do begin
                @(negedge clk);
                cyc++;
                if (cyc <= 4) begin
                    check("if_ram_a", bus.ram_a_o, addr + 32'(cyc - 1));
                    check("if_ram_wr", {31'b0, bus.ram_wr_o}, 32'h0);
                end
            end while (!bus.if_done_o && cyc < 40);
            bus.if_req_i = 1'b0;
            check("if_latency", 32'(cyc), 32'd5);
            @(negedge clk);
        end else begin
            for (int c = 0; c < flush_at; c++) begin
                @(negedge clk);
                if (bus.if_done_o) seen++;
            end
            bus.if_flush_i = 1'b1;
            bus.if_req_i   = 1'b0;
            @(negedge clk);
            bus.if_flush_i = 1'b0;
            for (int c = 0; c < 7; c++) begin
                if (bus.if_done_o) seen++;
                @(negedge clk);
            end
            check("flush_no_done", 32'(seen), 32'h0);
            check("flush_inst_held", bus.if_inst_o, last_inst);
        end
    endtask

    task automatic contention(input bit we, input logic [1:0] sz, input logic [31:0] maddr,
                              input logic [31:0] wd, input logic [31:0] iaddr);
        int n = nbytes(sz);
        int cyc = 0;
        bit mem_seen = 0;
        bus.mem_req_i   = 1'b1;
        bus.mem_we_i    = we;
        bus.mem_size_i  = sz;
        bus.mem_addr_i  = maddr;
        bus.mem_wdata_i = wd;
        bus.if_addr_i   = iaddr;
        bus.if_req_i    = 1'b1;
        if (we) model_store(maddr, n, wd);
        else last_rdata = model_load(maddr, n);
        exp_mem.push_back(last_rdata);
        last_inst = model_load(iaddr, 4);
        exp_if.push_back(last_inst);
        do begin
            @(negedge clk);
            cyc++;
            if (!mem_seen && bus.mem_done_o) begin
                mem_seen = 1;
                bus.mem_req_i = 1'b0;
                check("contention_mem_latency", 32'(cyc), 32'(n + 1));
            end
        end while (!bus.if_done_o && cyc < 60);
        bus.if_req_i = 1'b0;
        check("contention_if_latency", 32'(cyc), 32'(n + 7));
        @(negedge clk);
    endtask

    task automatic reset_mid_store(input logic [31:0] addr, input logic [31:0] wd);
        int seen = 0;
        bus.mem_req_i   = 1'b1;
        bus.mem_we_i    = 1'b1;
        bus.mem_size_i  = 2'b10;
        bus.mem_addr_i  = addr;
        bus.mem_wdata_i = wd;
        model_store(addr, 2, wd);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bus.mem_req_i = 1'b0;
        @(negedge clk);
        check("rst_ram_wr", {31'b0, bus.ram_wr_o}, 32'h0);
        check("rst_if_inst", bus.if_inst_o, 32'h0);
        check("rst_mem_rdata", bus.mem_rdata_o, 32'h0);
        rst = 1'b0;
        last_inst  = '0;
        last_rdata = '0;
        for (int c = 0; c < 6; c++) begin
            if (bus.mem_done_o) seen++;
            @(negedge clk);
        end
        check("rst_no_done", 32'(seen), 32'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFF8 + 32'($urandom_range(0, 7));
        return 32'h0000_3000 + 32'($urandom_range(0, 63));
    endfunction

    initial begin
        int mism;
        rst             = 1'b1;
        bus.if_req_i    = 1'b0;
        bus.if_addr_i   = '0;
        bus.if_flush_i  = 1'b0;
        bus.mem_req_i   = 1'b0;
        bus.mem_we_i    = 1'b0;
        bus.mem_size_i  = 2'b00;
        bus.mem_addr_i  = '0;
        bus.mem_wdata_i = '0;
        last_inst       = '0;
        last_rdata      = '0;
        repeat (3) @(negedge clk);
        check("reset_if_done", {31'b0, bus.if_done_o}, 32'h0);
        check("reset_mem_done", {31'b0, bus.mem_done_o}, 32'h0);
        check("reset_if_inst", bus.if_inst_o, 32'h0);
        check("reset_mem_rdata", bus.mem_rdata_o, 32'h0);
        check("reset_ram_wr", {31'b0, bus.ram_wr_o}, 32'h0);
        check("reset_ram_a", bus.ram_a_o, 32'h0);
        check("reset_ram_dout", {24'b0, bus.ram_dout_o}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        if_op(32'h100, 0);
        check("fetch_0x100", bus.if_inst_o, 32'h0010_0513);

        mem_op(1'b1, 2'b10, 32'h2000, 32'hDEAD_BEEF);
        mem_op(1'b0, 2'b01, 32'h2002, 32'h0);
        check("load_half_2002", bus.mem_rdata_o, 32'h0000_DEAD);

        contention(1'b0, 2'b00, 32'h10, 32'h0, 32'h100);
        check("contention_byte_0x10", bus.mem_rdata_o, 32'h0000_007F);

        if_op(32'h100, 2);
        if_op(32'h200, 0);
        if_op(32'h200, 4);

        reset_mid_store(32'h2100, 32'h1122_3344);

        mem_op(1'b0, 2'b10, 32'hFFFF_FFFE, 32'h0);

        for (int t = 0; t < 250; t++) begin
            logic [1:0]  sz = 2'($urandom_range(0, 3));
            logic [31:0] a  = rand_addr();
            logic [31:0] ia = rand_addr();
            logic [31:0] wd = $urandom;
            case ($urandom_range(0, 4))
                0:       if_op(ia, 0);
                1:       mem_op(1'b0, sz, a, 32'h0);
                2:       mem_op(1'b1, sz, a, wd);
                3:       contention(1'($urandom_range(0, 1)), sz, a, wd, ia);
                default: if_op(ia, int'($urandom_range(1, 4)));
            endcase
        end

        repeat (4) @(negedge clk);
        check("if_queue_drained", 32'(exp_if.size()), 32'h0);
        check("mem_queue_drained", 32'(exp_mem.size()), 32'h0);
        mism = 0;
        for (int i = 0; i < 16384; i++) begin
            if (dut_vld[i] != model_vld[i] || (model_vld[i] && dut_ram[i] !== model_ram[i])) begin
                if (mism == 0) $display("ram image differs at index %0h: got %h expected %h", i, dut_ram[i], model_ram[i]);
                mism++;
            end
        end
        check("ram_image", 32'(mism), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
        $fatal(1, "watchdog");
    end

endmodule
